// File: rtl/mem_lsu_if.sv
// Request/acknowledge port between the MEM-stage LSU and a variable-latency data memory.
// Signal-only bundle; request fields are held stable until mem_ack.
// master = LSU (initiator), slave = memory responder.
interface mem_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store initiator: word address, byte enables, lane-replicated stores, extended loads.
// Latency: issue->done 2 edges with ack in first REQ cycle; misaligned ops finish after 1 edge.
// Backpressure: stalls the pipeline until mem_ack; MEM_LSU_TIMEOUT_EN adds a bus-error abort.
module mem_lsu #(
    parameter logic [1:0] NONE = 2'b00,
    parameter logic [1:0] WORD = 2'b01,
    parameter logic [1:0] HALF = 2'b10,
    parameter logic [1:0] BYTE = 2'b11
`ifdef MEM_LSU_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ex_mem_valid,
    input  logic [1:0]  i_ex_mem_ls_bit,
    input  logic        i_ex_mem_mem_write,
    input  logic        i_ex_mem_ext_op,
    input  logic [31:0] i_ex_mem_addr,
    input  logic [31:0] i_ex_mem_wdata,
    mem_lsu_if.master   bus,
    output logic        o_lsu_stall,
    output logic        o_lsu_done,
    output logic [31:0] o_lsu_load_data,
    output logic        o_lsu_misalign,
    output logic        o_lsu_bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic        r_we;
    logic        r_ext;
    logic [1:0]  r_size;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_req;
    logic        r_done;
    logic        r_misalign;
    logic [31:0] r_load_data;

`ifdef MEM_LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;
`endif

    logic        w_op_vld;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    assign w_op_vld   = i_ex_mem_valid && (i_ex_mem_ls_bit != NONE);
    assign w_misalign = ((i_ex_mem_ls_bit == HALF) && i_ex_mem_addr[0]) ||
                        ((i_ex_mem_ls_bit == WORD) && (i_ex_mem_addr[1:0] != 2'b00));

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = i_ex_mem_wdata;
        case (i_ex_mem_ls_bit)
            BYTE: begin
                w_be    = 4'b0001 << i_ex_mem_addr[1:0];
                w_wdata = {4{i_ex_mem_wdata[7:0]}};
            end
            HALF: begin
                w_be    = i_ex_mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_ex_mem_wdata[15:0]}};
            end
            WORD: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Lane extraction uses the latched address so late EX/MEM changes cannot corrupt it.
    always_comb begin
        w_ld_byte = bus.mem_rdata[7:0];
        case (r_addr[1:0])
            2'b01:   w_ld_byte = bus.mem_rdata[15:8];
            2'b10:   w_ld_byte = bus.mem_rdata[23:16];
            2'b11:   w_ld_byte = bus.mem_rdata[31:24];
            default: w_ld_byte = bus.mem_rdata[7:0];
        endcase
    end

    assign w_ld_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        w_ld_data = bus.mem_rdata;
        case (r_size)
            BYTE:    w_ld_data = {{24{r_ext & w_ld_byte[7]}}, w_ld_byte};
            HALF:    w_ld_data = {{16{r_ext & w_ld_half[15]}}, w_ld_half};
            default: w_ld_data = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'h0;
            r_we        <= 1'b0;
            r_ext       <= 1'b0;
            r_size      <= NONE;
            r_be        <= 4'b0000;
            r_wdata     <= 32'h0;
            r_req       <= 1'b0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_load_data <= 32'h0;
`ifdef MEM_LSU_TIMEOUT_EN
            r_cnt       <= '0;
            r_bus_err   <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
`ifdef MEM_LSU_TIMEOUT_EN
            r_bus_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_op_vld) begin
                        r_addr  <= i_ex_mem_addr;
                        r_we    <= i_ex_mem_mem_write;
                        r_ext   <= i_ex_mem_ext_op;
                        r_size  <= i_ex_mem_ls_bit;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        if (w_misalign) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_misalign <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
`ifdef MEM_LSU_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_ack) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        if (!r_we) begin
                            r_load_data <= w_ld_data;
                        end
`ifdef MEM_LSU_TIMEOUT_EN
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= S_DONE;
                        r_req     <= 1'b0;
                        r_done    <= 1'b1;
                        r_bus_err <= 1'b1;
                        if (!r_we) begin
                            r_load_data <= 32'h0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
`endif
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stall drops in DONE so the pipeline advances on that edge without re-issuing.
    assign o_lsu_stall     = ((r_state == S_IDLE) && w_op_vld) || (r_state == S_REQ);
    assign o_lsu_done      = r_done;
    assign o_lsu_load_data = r_load_data;
    assign o_lsu_misalign  = r_misalign;
`ifdef MEM_LSU_TIMEOUT_EN
    assign o_lsu_bus_err   = r_bus_err;
`else
    assign o_lsu_bus_err   = 1'b0;
`endif

    assign bus.mem_req   = r_req;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = {r_addr[31:2], 2'b00};
    assign bus.mem_be    = r_be;
    assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: per-cycle compare against a transaction-level model plus literal pins.
// Define MEM_LSU_TIMEOUT_EN to also exercise the bus-error abort with a 4-cycle limit.
module tb_mem_lsu;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] WORD = 2'b01;
    localparam logic [1:0] HALF = 2'b10;
    localparam logic [1:0] BYTE = 2'b11;
`ifdef MEM_LSU_TIMEOUT_EN
    localparam int TO_CYC = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [1:0]  ls;
    logic        wr;
    logic        ext_op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        stall;
    logic        done;
    logic [31:0] ld;
    logic        mis;
    logic        berr;

    mem_lsu_if bus_if();

`ifdef MEM_LSU_TIMEOUT_EN
    mem_lsu #(.TIMEOUT_CYCLES(TO_CYC)) dut (
`else
    mem_lsu dut (
`endif
        .i_clk              (clk),
        .i_rst              (rst),
        .i_ex_mem_valid     (valid),
        .i_ex_mem_ls_bit    (ls),
        .i_ex_mem_mem_write (wr),
        .i_ex_mem_ext_op    (ext_op),
        .i_ex_mem_addr      (addr),
        .i_ex_mem_wdata     (wd),
        .bus                (bus_if.master),
        .o_lsu_stall        (stall),
        .o_lsu_done         (done),
        .o_lsu_load_data    (ld),
        .o_lsu_misalign     (mis),
        .o_lsu_bus_err      (berr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model expectations for the current cycle.
    logic        chk_en = 1'b0;
    logic        exp_req = 1'b0, exp_stall = 1'b0, exp_done = 1'b0, exp_mis = 1'b0, exp_berr = 1'b0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = 32'h0, exp_wd = 32'h0, exp_ld = 32'h0;
    logic [3:0]  exp_be = 4'h0;

    // Observations gathered by the compare process.
    int n_stall = 0, n_done = 0, n_req = 0, n_mis = 0, n_berr = 0;
    logic [31:0] cap_addr = 32'h0, cap_wd = 32'h0;
    logic [3:0]  cap_be = 4'h0;
    logic        cap_we = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int lane;
        lane = int'(a % 32'd4);
        if (sz == BYTE) return 4'(1 << lane);
        if (sz == HALF) return (lane >= 2) ? 4'hC : 4'h3;
        if (sz == WORD) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
        if (sz == BYTE) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == HALF) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic ext,
                                         input logic [31:0] a, input logic [31:0] rd);
        int lane;
        logic [31:0] v;
        lane = int'(a % 32'd4);
        if (sz == BYTE) begin
            v = (rd >> (8 * lane)) & 32'hFF;
            if (ext && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == HALF) begin
            v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
            if (ext && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("mem_req",   32'(bus_if.mem_req), 32'(exp_req));
                check("lsu_stall", 32'(stall),          32'(exp_stall));
                check("lsu_done",  32'(done),           32'(exp_done));
                check("misalign",  32'(mis),            32'(exp_mis));
                check("bus_err",   32'(berr),           32'(exp_berr));
                check("load_data", ld,                  exp_ld);
                if (exp_req) begin
                    check("mem_addr",  bus_if.mem_addr,        exp_addr);
                    check("mem_be",    32'(bus_if.mem_be),     32'(exp_be));
                    check("mem_we",    32'(bus_if.mem_we),     32'(exp_we));
                    check("mem_wdata", bus_if.mem_wdata,       exp_wd);
                end
            end
            if (stall) n_stall++;
            if (done) n_done++;
            if (mis) n_mis++;
            if (berr) n_berr++;
            if (bus_if.mem_req) begin
                n_req++;
                cap_addr = bus_if.mem_addr;
                cap_be   = bus_if.mem_be;
                cap_we   = bus_if.mem_we;
                cap_wd   = bus_if.mem_wdata;
            end
        end
    endtask

    // One op from IDLE to IDLE; dly = REQ cycles before ack (negative = never ack).
    task automatic do_op(input logic [1:0] sz, input logic we, input logic ext, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input int dly);
        int lane, k;
        bit misal, fin, to;
        lane  = int'(a % 32'd4);
        misal = (sz == HALF && (lane % 2) == 1) || (sz == WORD && lane != 0);
        valid = 1'b1; ls = sz; wr = we; ext_op = ext; addr = a; wd = d;
        bus_if.mem_ack = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b1; exp_done = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0;
        step();
        ls = ~sz; wr = ~we; ext_op = ~ext; addr = ~a; wd = ~d;
        if (misal) begin
            valid = 1'b0; exp_stall = 1'b0; exp_done = 1'b1; exp_mis = 1'b1;
        end else begin
            exp_req = 1'b1; exp_addr = a - 32'(lane); exp_be = m_be(sz, a);
            exp_we = we; exp_wd = m_wd(sz, d);
            k = 0; fin = 1'b0; to = 1'b0;
            while (!fin) begin
                if (k >= 64) begin
                    checks++; errors++;
                    $display("FAIL ack_wait actual=%0d cycles required=done", k);
                    fin = 1'b1;
                end else begin
                    bus_if.mem_ack   = (dly >= 0 && k == dly);
                    bus_if.mem_rdata = bus_if.mem_ack ? rd : ~rd;
`ifdef MEM_LSU_TIMEOUT_EN
                    if (!bus_if.mem_ack && k == TO_CYC - 1) to = 1'b1;
`endif
                    if (bus_if.mem_ack || to) fin = 1'b1;
                    step();
                    k++;
                end
            end
            bus_if.mem_ack = 1'b0; valid = 1'b0;
            exp_req = 1'b0; exp_stall = 1'b0; exp_done = 1'b1; exp_berr = to;
            if (!we) exp_ld = to ? 32'h0 : m_ld(sz, ext, a, rd);
        end
        step();
        exp_done = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_stall, s_done, s_req, s_mis, s_berr;
        rst = 1'b1; valid = 1'b0; ls = NONE; wr = 1'b0; ext_op = 1'b0; addr = 32'h0; wd = 32'h0;
        bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'h0;
        fork
            compare_loop();
            begin
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                check("rst_req",   32'(bus_if.mem_req), 32'h0);
                check("rst_addr",  bus_if.mem_addr,     32'h0);
                check("rst_be",    32'(bus_if.mem_be),  32'h0);
                check("rst_wdata", bus_if.mem_wdata,    32'h0);
                check("rst_ld",    ld,                  32'h0);
                chk_en = 1'b1;
                step();

                s_stall = n_stall; s_done = n_done;
                do_op(WORD, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 2);
                check("sw_addr",   cap_addr,            32'h10);
                check("sw_be",     32'(cap_be),         32'hF);
                check("sw_we",     32'(cap_we),         32'h1);
                check("sw_stall",  32'(n_stall - s_stall), 32'd4);
                check("sw_done",   32'(n_done - s_done),   32'd1);

                s_stall = n_stall;
                do_op(BYTE, 1'b1, 1'b0, 32'h23, 32'h0000_00A5, 32'h0, 0);
                check("sb_be",     32'(cap_be),            32'h8);
                check("sb_wdata",  cap_wd,                 32'hA5A5_A5A5);
                check("sb_stall",  32'(n_stall - s_stall), 32'd2);

                do_op(HALF, 1'b1, 1'b0, 32'h22, 32'h1234_ABCD, 32'h0, 1);
                check("sh_be",     32'(cap_be), 32'hC);
                check("sh_wdata",  cap_wd,      32'hABCD_ABCD);

                do_op(BYTE, 1'b0, 1'b1, 32'h41, 32'h0, 32'h0000_8000, 0);
                check("lb_sext",   ld, 32'hFFFF_FF80);
                do_op(BYTE, 1'b0, 1'b0, 32'h41, 32'h0, 32'h0000_8000, 3);
                check("lb_zext",   ld, 32'h0000_0080);
                do_op(HALF, 1'b0, 1'b1, 32'h42, 32'h0, 32'h9ABC_0000, 1);
                check("lh_sext",   ld, 32'hFFFF_9ABC);

                s_req = n_req; s_mis = n_mis;
                do_op(WORD, 1'b0, 1'b0, 32'h46, 32'h0, 32'h5555_5555, 0);
                do_op(HALF, 1'b0, 1'b1, 32'h43, 32'h0, 32'h5555_5555, 0);
                check("mis_noreq", 32'(n_req - s_req), 32'd0);
                check("mis_pulse", 32'(n_mis - s_mis), 32'd2);
                check("mis_ld",    ld,                 32'hFFFF_9ABC);

                do_op(WORD, 1'b0, 1'b0, 32'h40, 32'h0, 32'h1122_3344, 2);
                do_op(BYTE, 1'b1, 1'b0, 32'h40, 32'h77, 32'hFFFF_FFFF, 0);
                check("st_keep_ld", ld, 32'h1122_3344);
                do_op(BYTE, 1'b0, 1'b1, 32'h43, 32'h0, 32'h8000_0000, 1);
                do_op(HALF, 1'b0, 1'b0, 32'h40, 32'h0, 32'h1234_8765, 0);
                check("lh_zext",   ld, 32'h0000_8765);
                do_op(BYTE, 1'b0, 1'b1, 32'h42, 32'h0, 32'h007F_0000, 0);
                check("lb_pos",    ld, 32'h0000_007F);

`ifdef MEM_LSU_TIMEOUT_EN
                do_op(WORD, 1'b0, 1'b0, 32'h50, 32'h0, 32'hCAFE_F00D, TO_CYC - 1);
                check("to_edge_ld", ld, 32'hCAFE_F00D);
                s_req = n_req; s_berr = n_berr;
                do_op(WORD, 1'b0, 1'b0, 32'h54, 32'h0, 32'h1357_9BDF, -1);
                check("to_req",    32'(n_req - s_req),   32'(TO_CYC));
                check("to_berr",   32'(n_berr - s_berr), 32'd1);
                check("to_ld",     ld,                   32'h0);
`else
                s_berr = n_berr;
`endif

                // Reset while a load sits in REQ.
                valid = 1'b1; ls = WORD; wr = 1'b0; ext_op = 1'b0; addr = 32'h80; wd = 32'h0;
                exp_stall = 1'b1;
                step();
                exp_req = 1'b1; exp_addr = 32'h80; exp_be = 4'hF; exp_we = 1'b0; exp_wd = 32'h0;
                step();
                rst = 1'b1; valid = 1'b0;
                step();
                rst = 1'b0; exp_req = 1'b0; exp_stall = 1'b0; exp_ld = 32'h0;
                check("rr_addr",  bus_if.mem_addr,    32'h0);
                check("rr_be",    32'(bus_if.mem_be), 32'h0);
                check("rr_wdata", bus_if.mem_wdata,   32'h0);
                s_done = n_done;
                bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'hFFFF_FFFF;
                step();
                bus_if.mem_ack = 1'b0;
                repeat (3) step();
                check("rr_nodone", 32'(n_done - s_done), 32'd0);
                check("berr_total", 32'(n_berr - s_berr), 32'd0);
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
